// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   IF-stage fetch sequencer for the 32-bit MIPS-style core. Owns the PC,
//   drives the combinational instruction memory and buffers fetched words in
//   a small FIFO that decode drains through a valid/ready handshake.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   imem_addr  [31:0] fetch address (always the current pc)
//   imem_data  [31:0] instruction word for imem_addr (combinational memory)
//   id_valid          queue head holds an instruction
//   id_ready          decode takes the head this cycle
//   id_instr   [31:0] head instruction (0 when queue empty)
//   id_pc      [31:0] head pc (0 when queue empty)
//   redirect_valid    one-cycle taken branch/jump pulse
//   redirect_target   new pc for a redirect
//   halt_req          level; blocks new fetches while high
//   fetch_fault       sticky flag: pc was out of range or misaligned
//   fault_pc   [31:0] pc that raised fetch_fault
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HALTED = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  state_t          state;
  logic [31:0]     pc;
  fq_entry_t       fq_mem [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic pc_legal, fetch_try, q_full, pop, push, fault_hit;

  assign imem_addr = pc;

  // A fetch is legal only for word-aligned addresses inside the memory span.
  assign pc_legal  = (pc < 32'(IMEM_BYTES)) && (pc[1:0] == 2'b00);
  // Fetch attempt: FETCH state, nothing overriding it this cycle.
  assign fetch_try = (state == S_FETCH) && !halt_req && !redirect_valid;
  assign q_full    = (count == CW'(QDEPTH));

  assign id_valid  = (count != '0);
  assign pop       = id_valid && id_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push      = fetch_try && pc_legal && (!q_full || pop);
  assign fault_hit = fetch_try && !pc_legal;

  assign id_instr  = id_valid ? fq_mem[rd_ptr].instr : '0;
  assign id_pc     = id_valid ? fq_mem[rd_ptr].pc    : '0;

  // Storage needs no reset: the outputs are gated by count.
  always_ff @(posedge clk) begin
    if (!reset && push)
      fq_mem[wr_ptr] <= '{pc: pc, instr: imem_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over everything; a concurrent pop is the branch itself
      // and needs no separate bookkeeping since the queue empties anyway.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pc          <= redirect_target;
      state       <= halt_req ? S_HALTED : S_FETCH;
      fetch_fault <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        S_FETCH: begin
          if (halt_req) begin
            state <= S_HALTED;
          end else if (fault_hit) begin
            state       <= S_FAULT;
            fetch_fault <= 1'b1;
            fault_pc    <= pc;
          end
        end
        // Leaving HALTED costs one cycle; fetching restarts next edge.
        S_HALTED: if (!halt_req) state <= S_FETCH;
        // Only a redirect or reset leaves FAULT.
        S_FAULT:  state <= S_FAULT;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the 32-bit MIPS-style core. Sits in the IF stage in front of the combinational instruction memory (byte address in, 32-bit word out).
- Owns the PC, drives the memory address and buffers fetched words in a small queue. Presents the queue to decode with a valid/ready handshake.
- Handles branch/jump redirects, halt requests and out-of-range or misaligned fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 64, legal address span; a fetch is legal iff pc < IMEM_BYTES.
- QDEPTH, 2, fetch queue entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  address to instruction memory; always equals pc.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- id_valid  output  1  queue head holds a valid instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_instr  output  32  instruction at queue head.
- id_pc  output  32  PC of id_instr.
- redirect_valid  input  1  branch/jump taken; one-cycle pulse.
- redirect_target  input  32  new PC.
- halt_req  input  1  level; suppresses new fetches while high.
- fetch_fault  output  1  sticky fault flag.
- fault_pc  output  32  PC that caused the fault.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset values: pc=RESET_PC, queue empty, id_valid=0, id_instr=0, id_pc=0, fetch_fault=0, fault_pc=0, state=FETCH. Reset mid-operation discards all queued entries in the same edge.
- States:
  - FETCH: fetch each cycle when allowed.
  - HALTED: entered when halt_req=1. No pushes; the queue drains. Returns to FETCH on the first cycle halt_req=0.
  - FAULT: no pushes; the queue drains.
- Push rule: in FETCH, with halt_req=0, redirect_valid=0 and pc legal (pc < IMEM_BYTES and pc[1:0]==0):
  - Push {pc, imem_data} when count<QDEPTH, or count==QDEPTH with a pop in the same cycle.
  - On push, pc <= pc+4 (32-bit wrap). Throughput is 1 instruction/cycle.
- Pop rule: pop when id_valid && id_ready. id_* are combinational from the queue head, so the first instruction reaches id_valid one cycle after it is fetched.
- Full queue with no pop: pc holds and there is no push (stall). imem_addr stays stable.
- Illegal pc in FETCH (pc >= IMEM_BYTES or pc[1:0]!=0):
  - Go to FAULT; set fetch_fault=1 and fault_pc=pc. No push.
  - The queue still drains normally.
- Redirect (highest priority, any state except reset):
  - Flush the queue and set pc <= redirect_target. Any push that cycle is dropped.
  - A simultaneous pop still counts as accepted; it is the branch itself.
  - Next state: FETCH, or HALTED if halt_req=1. fetch_fault clears.
  - id_valid=0 on the cycle after a redirect. The first target instruction is visible 2 cycles after the redirect edge.
  - A redirect to an illegal target re-enters FAULT on the next fetch attempt with fault_pc=target.
- Halt and redirect in the same cycle: the redirect is applied and the state becomes HALTED.
- Queue pointers wrap modulo QDEPTH. Count ranges 0..QDEPTH and never overflows or underflows.

Test Plan:
- Reset release, id_ready=1 held, memory words at 0,4,8 -> id_pc sequence 0,4,8 on consecutive cycles; id_valid first high 1 cycle after reset deasserts.
- id_ready=0 for 5 cycles from reset -> exactly 2 pushes (pc=8, imem_addr held at 8). Raise id_ready -> heads 0,4,8 in order with no gaps or duplicates.
- Redirect to 0x20 while head is pc=4 and accepted -> the queue entry for pc=8 is dropped; id_valid=0 for one cycle; next id_pc=0x20 with instr = mem word at 0x20.
- Sequential fetch past the last legal word (IMEM_BYTES=64, pc reaches 64) -> fetch_fault=1, fault_pc=64, no further pushes; a later redirect to 0 clears the fault and fetching resumes.
- Redirect to 0x06 (misaligned) -> FAULT with fault_pc=0x06. halt_req high for 3 cycles mid-stream -> no pushes, pc frozen, queue drains, then resumes at the same pc.
- Assert reset while queue full and in FAULT -> next cycle id_valid=0, fetch_fault=0, pc=RESET_PC.
